// File: rtl/wvl_capture_ctrl_if.sv
// BRAM write-port bundle between the capture controller and the snapshot BRAM.
//   bram_we    write enable
//   bram_addr  write address (ADDR_W bits)
//   bram_din   write data (DATA_W bits)
// Modports: master = controller (drives), slave = BRAM side (receives).
interface wvl_capture_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;

  modport master (output bram_we, output bram_addr, output bram_din);
  modport slave  (input bram_we, input bram_addr, input bram_din);
endinterface

// File: rtl/wvl_capture_ctrl.sv
// Snapshot capture sequencer: software arms it through ctrl_word, it runs
// holdoff -> trigger -> capture and writes datapath samples into the capture BRAM.
// Ports:
//   user_clk, user_rst_n  clock, asynchronous active-low reset
//   ctrl_word             [0] start (rising edge), [1] trig_sel, [2] abort, [31:16] holdoff
//   len_word              words to capture (0 or > 2**ADDR_W means 2**ADDR_W)
//   ext_trig              external trigger level, looked at in WAIT_TRIG only
//   din, din_valid        datapath sample stream
//   bram                  BRAM write port (master side of wvl_capture_ctrl_if)
//   status                [2:0] state, [3] done, [4] aborted, [31:16] words written
//   done_pulse            one cycle high on entry to DONE
// Optional feature: define WVL_CAPTURE_CTRL_TIMESTAMP_EN to write a free-running cycle
// count to address 0 on trigger; samples then start at address 1 and the timestamp
// counts toward the capture length.
module wvl_capture_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [31:0]         ctrl_word,
  input  logic [ADDR_W:0]     len_word,
  input  logic                ext_trig,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  wvl_capture_ctrl_if.master  bram,
  output logic [31:0]         status,
  output logic                done_pulse
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHoldoff = 3'd1;
  localparam logic [2:0] StWaitTrig = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_q, state_d;
  logic              start_prev_q;
  logic [15:0]       hold_q, hold_d;
  logic              trig_sel_q, trig_sel_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_pulse_q, done_pulse_d;

  logic              start;
  logic              abort;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   count_inc;
  logic [15:0]       count_ext;
  logic              unused_ctrl;

  assign start       = ctrl_word[0] & ~start_prev_q;
  assign abort       = ctrl_word[2];
  assign len_clamped = ((len_word == '0) || (len_word > MaxLen)) ? MaxLen : len_word;
  assign count_inc   = count_q + 1'b1;
  assign count_ext   = 16'(count_q);
  assign unused_ctrl = ^ctrl_word[15:3];

`ifdef WVL_CAPTURE_CTRL_TIMESTAMP_EN
  logic [DATA_W-1:0] ts_q;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    trig_sel_d   = trig_sel_q;
    len_d        = len_q;
    count_d      = count_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_pulse_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        // Abort held together with start suppresses the new capture.
        if (start && !abort) begin
          done_d     = 1'b0;
          aborted_d  = 1'b0;
          count_d    = '0;
          hold_d     = ctrl_word[31:16];
          trig_sel_d = ctrl_word[1];
          len_d      = len_clamped;
          state_d    = (ctrl_word[31:16] != 16'd0) ? StHoldoff : StWaitTrig;
        end
      end
      StHoldoff: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else begin
          hold_d = hold_q - 16'd1;
          if (hold_q == 16'd1) state_d = StWaitTrig;
        end
      end
      StWaitTrig: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (!trig_sel_q || ext_trig) begin
          state_d = StCapture;
`ifdef WVL_CAPTURE_CTRL_TIMESTAMP_EN
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = ts_q;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d      = StDone;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end
`endif
        end
      end
      StCapture: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (din_valid) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = din;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d      = StDone;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      hold_q       <= '0;
      trig_sel_q   <= 1'b0;
      len_q        <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= ctrl_word[0];
      hold_q       <= hold_d;
      trig_sel_q   <= trig_sel_d;
      len_q        <= len_d;
      count_q      <= count_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bram.bram_we   = we_q;
  assign bram.bram_addr = addr_q;
  assign bram.bram_din  = wdata_q;
  assign status         = {count_ext, 11'd0, aborted_q, done_q, state_q};
  assign done_pulse     = done_pulse_q;

endmodule
